uart_reg_responder: RTL and testbench

- Command responder on the byte side of the UART block. It consumes received bytes (rx data, done, error) and drives transmit bytes (tx data, start) back to the host.
- It decodes a 2/3-byte register-access protocol and converts it into single-cycle register bus reads and writes.
- It transmits one response byte per frame, making the device the answering end of a host-initiated link.

---
 rtl/uart_proto_pkg.sv | 38 +++
 rtl/uart_evt_edge.sv | 35 +++
 rtl/uart_reg_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_reg_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_proto_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_proto_pkg
//  Description : Shared definitions for the byte-level register-access
//                protocol: command codes, default response codes and the
//                responder state encoding. Used by the responder RTL and by
//                any host-side model that speaks the same protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_proto_pkg;

    // Command bytes sent by the host as the first byte of a frame
    localparam logic [7:0] CMD_WRITE   = 8'h57;   // 'W' ADDR DATA
    localparam logic [7:0] CMD_READ    = 8'h52;   // 'R' ADDR

    // Default single-byte responses
    localparam logic [7:0] ACK_DEFAULT = 8'h4B;   // 'K' write accepted
    localparam logic [7:0] NAK_DEFAULT = 8'h3F;   // '?' unknown command
    localparam logic [7:0] ERR_DEFAULT = 8'h45;   // 'E' rx error mid-frame

    // Responder state encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_ADDR   = 3'd1,
        ST_GET_DATA   = 3'd2,
        ST_RD_STROBE  = 3'd3,
        ST_RD_CAPTURE = 3'd4,
        ST_TX_REQ     = 3'd5,
        ST_TX_WAIT    = 3'd6
    } state_t;

    // True for the command bytes that open a multi-byte frame
    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_evt_edge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_evt_edge
//  Description : Registers a level from a slower clock domain-derived source
//                and produces a single-cycle pulse on its rising edge. A level
//                held high for many cycles yields exactly one pulse.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_level     - input level
//                o_rise      - one-cycle pulse, one cycle after i_level rises
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_evt_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level;
    logic r_level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level   <= i_level;
            r_level_d <= r_level;
        end
    end

    assign o_rise = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_responder
//  Description : Byte-side command responder for a UART. Decodes
//                'W' ADDR DATA and 'R' ADDR frames into single-cycle register
//                bus strobes and answers each frame with one response byte.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                rx_data/done/error   - receiver byte interface
//                tx_busy, tx_start,
//                tx_data              - transmitter handshake
//                reg_wr, reg_rd,
//                reg_addr, reg_wdata,
//                reg_rdata            - register bus
//                busy                 - responder not idle
//                overrun              - byte event dropped during response
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_responder
    import uart_proto_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT,
    parameter logic [7:0] ERR_BYTE       = ERR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_error,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       reg_wr,
    output logic       reg_rd,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       overrun
);

    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_done_evt;
    logic               w_err_evt;
    logic               w_in_frame;
    logic               w_timeout;
    logic [7:0]         r_rx_data;
    logic [7:0]         r_cmd;
    logic [7:0]         r_reg_addr;
    logic [7:0]         r_reg_wdata;
    logic [7:0]         r_tx_data;
    logic               r_reg_wr;
    logic [c_TO_W-1:0]  r_to_cnt;

    // ------------------------------------------------------------------------
    // Event detection; rx_data is delayed alongside so it lines up with the
    // registered done pulse even when rx_done is only a single cycle wide.
    // ------------------------------------------------------------------------
    uart_evt_edge u_done_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (rx_done),
        .o_rise  (w_done_evt)
    );

    uart_evt_edge u_err_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (rx_error),
        .o_rise  (w_err_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= 8'h00;
        end else begin
            r_rx_data <= rx_data;
        end
    end

    assign w_in_frame = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
    assign w_timeout  = w_in_frame && (r_to_cnt == c_TO_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Inside a frame an error beats a byte, and a byte
    // beats a timeout expiring in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_done_evt && !w_err_evt) begin
                    w_next_state = is_known_cmd(r_rx_data) ? ST_GET_ADDR : ST_TX_REQ;
                end
            end
            ST_GET_ADDR: begin
                if (w_err_evt) begin
                    w_next_state = ST_TX_REQ;
                end else if (w_done_evt) begin
                    w_next_state = (r_cmd == CMD_WRITE) ? ST_GET_DATA : ST_RD_STROBE;
                end else if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (w_err_evt || w_done_evt) begin
                    w_next_state = ST_TX_REQ;
                end else if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_STROBE:  w_next_state = ST_RD_CAPTURE;
            ST_RD_CAPTURE: w_next_state = ST_TX_REQ;
            ST_TX_REQ: begin
                if (tx_busy) begin
                    w_next_state = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:       w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        tx_start = 1'b0;
        reg_rd   = 1'b0;
        busy     = 1'b0;
        overrun  = 1'b0;
        tx_start = (r_state == ST_TX_REQ);
        reg_rd   = (r_state == ST_RD_STROBE);
        busy     = (r_state != ST_IDLE);
        overrun  = w_done_evt && ((r_state == ST_RD_STROBE)  ||
                                  (r_state == ST_RD_CAPTURE) ||
                                  (r_state == ST_TX_REQ)     ||
                                  (r_state == ST_TX_WAIT));
    end

    // ------------------------------------------------------------------------
    // Frame datapath: command/address/data latches, response byte and the
    // write strobe, which is registered so it lands the cycle after the
    // final data byte event.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd       <= 8'h00;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_tx_data   <= 8'h00;
            r_reg_wr    <= 1'b0;
        end else begin
            r_reg_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_done_evt && !w_err_evt) begin
                        r_cmd <= r_rx_data;
                        if (!is_known_cmd(r_rx_data)) begin
                            r_tx_data <= NAK_BYTE;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (w_err_evt) begin
                        r_tx_data <= ERR_BYTE;
                    end else if (w_done_evt) begin
                        r_reg_addr <= r_rx_data;
                    end
                end
                ST_GET_DATA: begin
                    if (w_err_evt) begin
                        r_tx_data <= ERR_BYTE;
                    end else if (w_done_evt) begin
                        r_reg_wdata <= r_rx_data;
                        r_reg_wr    <= 1'b1;
                        r_tx_data   <= ACK_BYTE;
                    end
                end
                ST_RD_CAPTURE: begin
                    r_tx_data <= reg_rdata;
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timeout; idle outside the address/data collection states
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_done_evt || w_err_evt || !w_in_frame || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    assign tx_data   = r_tx_data;
    assign reg_wr    = r_reg_wr;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_responder
//  Description : Self-checking bench for uart_reg_responder. Stimulus pushes
//                expected bus/response events into a queue; a monitor pops
//                and compares whenever the DUT strobes the bus, starts a
//                transmission or flags an overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_responder;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_TX = 2;
    localparam int K_OV = 3;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       overrun;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_tx = 1'b0;
    logic tx_hold = 1'b0;
    int   tx_len  = 8;
    int   tx_cnt  = 0;

    uart_reg_responder #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_error  (rx_error),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Transmitter model: accepts tx_start, stays busy for tx_len+1 cycles
    always @(negedge clk) begin
        if (rst) begin
            tx_busy = 1'b0;
            tx_cnt  = 0;
        end else if (tx_busy) begin
            if (tx_cnt == 0) tx_busy = 1'b0;
            else             tx_cnt  = tx_cnt - 1;
        end else if (tx_start && !tx_hold) begin
            tx_busy = 1'b1;
            tx_cnt  = tx_len;
        end
    end

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        q.push_back(e);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard compare for one observed DUT event
    task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_evt: got kind=%0d a=%h d=%h, expected none", kind, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a !== a || (kind == K_WR && e.d !== d)) begin
                n_err++;
                $display("FAIL evt_compare: got kind=%0d a=%h d=%h, expected kind=%0d a=%h d=%h",
                         kind, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr)               observe(K_WR, reg_addr, reg_wdata);
            if (reg_rd)               observe(K_RD, reg_addr, 8'h00);
            if (tx_start && !prev_tx) observe(K_TX, tx_data, 8'h00);
            if (overrun)              observe(K_OV, 8'h00, 8'h00);
        end
        prev_tx = tx_start;
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got busy=1 after 400 cycles, expected busy=0", name);
        end
    endtask

    task automatic wait_tx_busy();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_tx_busy: got tx_busy=0 after 50 cycles, expected 1");
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk8({name, "_ctrl"}, {3'b000, tx_start, reg_wr, reg_rd, busy, overrun}, 8'h00);
        chk8({name, "_tx_data"}, tx_data, 8'h00);
        chk8({name, "_reg_addr"}, reg_addr, 8'h00);
        chk8({name, "_reg_wdata"}, reg_wdata, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        rx_error  = 1'b0;
        reg_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Write 57 10 A5
        push(K_WR, 8'h10, 8'hA5);
        push(K_TX, 8'h4B, 8'h00);
        send_byte(8'h57, 4);
        send_byte(8'h10, 4);
        send_byte(8'hA5, 4);
        wait_idle("write_idle");
        chk8("write_addr", reg_addr, 8'h10);
        chk8("write_wdata", reg_wdata, 8'hA5);

        // Read 52 20 with rdata 3C
        reg_rdata = 8'h3C;
        push(K_RD, 8'h20, 8'h00);
        push(K_TX, 8'h3C, 8'h00);
        send_byte(8'h52, 4);
        send_byte(8'h20, 4);
        wait_idle("read_idle");

        // Unknown command with rx_done held 16 cycles
        push(K_TX, 8'h3F, 8'h00);
        send_byte(8'h7F, 16);
        wait_idle("nak_idle");

        // Timeout after 57 10, then a clean read
        send_byte(8'h57, 4);
        send_byte(8'h10, 4);
        repeat (110) @(negedge clk);
        chk8("timeout_busy", {7'd0, busy}, 8'h00);
        reg_rdata = 8'h99;
        push(K_RD, 8'h10, 8'h00);
        push(K_TX, 8'h99, 8'h00);
        send_byte(8'h52, 4);
        send_byte(8'h10, 4);
        wait_idle("post_timeout_idle");

        // rx_error after the command byte
        push(K_TX, 8'h45, 8'h00);
        send_byte(8'h57, 4);
        @(negedge clk);
        rx_error = 1'b1;
        repeat (3) @(negedge clk);
        rx_error = 1'b0;
        wait_idle("error_idle");

        // Byte arriving during TX_WAIT
        tx_len = 30;
        push(K_TX, 8'h3F, 8'h00);
        push(K_OV, 8'h00, 8'h00);
        send_byte(8'h7F, 4);
        wait_tx_busy();
        send_byte(8'h55, 4);
        wait_idle("overrun_idle");
        tx_len = 8;

        // Reset while tx_start is asserted
        tx_hold = 1'b1;
        push(K_TX, 8'h3F, 8'h00);
        send_byte(8'h7F, 4);
        chk8("pre_reset_tx_start", {7'd0, tx_start}, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst     = 1'b0;
        tx_hold = 1'b0;
        @(negedge clk);

        // Normal write after reset
        push(K_WR, 8'h01, 8'hFF);
        push(K_TX, 8'h4B, 8'h00);
        send_byte(8'h57, 4);
        send_byte(8'h01, 4);
        send_byte(8'hFF, 4);
        wait_idle("final_idle");
        repeat (5) @(negedge clk);
        chk8("queue_left", 8'(q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
